// File: rtl/fmul_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa product,
// then normalise, round-to-nearest-even and finish, for a fixed 27-cycle latency.
module fmul_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        done,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, MUL, NORM, RND, FIN} state_t;

    state_t             state_q, state_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic        [23:0] ma_q, ma_d, mb_q, mb_d;
    logic        [47:0] prod_q, prod_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               spec_q, spec_d;
    logic        [31:0] spec_val_q, spec_val_d;
    logic        [23:0] mant_q, mant_d;
    logic        [2:0]  grs_q, grs_d;
    logic        [31:0] y_q, y_d;

    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, op_sign;
    logic        [47:0] add_term;
    logic               round_up;
    logic        [24:0] rsum;
    logic signed [9:0]  exp_r;
    logic        [22:0] frac_r;

    assign a_zero  = (a[30:23] == 8'h00);
    assign b_zero  = (b[30:23] == 8'h00);
    assign a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign op_sign = a[31] ^ b[31];

    assign add_term = mb_q[cnt_q] ? ({24'd0, ma_q} << cnt_q) : 48'd0;

    // Guard must be set, then round up on anything beyond a tie or an odd lsb.
    assign round_up = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);
    assign rsum     = {1'b0, mant_q} + {24'd0, round_up};
    assign exp_r    = exp_q + $signed({9'd0, rsum[24]});
    assign frac_r   = rsum[24] ? rsum[23:1] : rsum[22:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        prod_d     = prod_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        mant_d     = mant_q;
        grs_d      = grs_q;
        y_d        = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = MUL;
                    cnt_d      = 5'd0;
                    ma_d       = {1'b1, a[22:0]};
                    mb_d       = {1'b1, b[22:0]};
                    prod_d     = 48'd0;
                    sign_d     = op_sign;
                    exp_d      = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
                    spec_d     = 1'b1;
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
                        spec_val_d = 32'h7FC0_0000;
                    else if (a_inf || b_inf)
                        spec_val_d = {op_sign, 8'hFF, 23'd0};
                    else if (a_zero || b_zero)
                        spec_val_d = {op_sign, 31'd0};
                    else begin
                        spec_d     = 1'b0;
                        spec_val_d = 32'd0;
                    end
                end
            end
            MUL: begin
                prod_d = prod_q + add_term;
                if (cnt_q == 5'd23) begin
                    cnt_d   = 5'd0;
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            NORM: begin
                state_d = RND;
                if (prod_q[47]) begin
                    mant_d = prod_q[47:24];
                    grs_d  = {prod_q[23], prod_q[22], |prod_q[21:0]};
                    exp_d  = exp_q + 10'sd1;
                end else begin
                    mant_d = prod_q[46:23];
                    grs_d  = {prod_q[22], prod_q[21], |prod_q[20:0]};
                end
            end
            RND: begin
                state_d = FIN;
                exp_d   = exp_r;
                if (spec_q)
                    y_d = spec_val_q;
                else if (exp_r >= 10'sd255)
                    y_d = {sign_q, 8'hFF, 23'd0};
                else if (exp_r <= 10'sd0)
                    y_d = {sign_q, 31'd0};
                else
                    y_d = {sign_q, exp_r[7:0], frac_r};
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            ma_q       <= 24'd0;
            mb_q       <= 24'd0;
            prod_q     <= 48'd0;
            exp_q      <= 10'sd0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
            mant_q     <= 24'd0;
            grs_q      <= 3'd0;
            y_q        <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            prod_q     <= prod_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            mant_q     <= mant_d;
            grs_q      <= grs_d;
            y_q        <= y_d;
        end
    end

    assign y    = y_q;
    assign done = (state_q == FIN);
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_fmul_seq.sv
// Bench for fmul_seq: arithmetic reference model with cycle-level expectations,
// compared every cycle, plus directed vectors with hand-computed results.
module tb_fmul_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] y;
    logic        done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    fmul_seq dut (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
        .y(y), .done(done), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference product computed with wide integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] z);
        int          ex, ez, e, sh;
        logic        s;
        longint unsigned p, q, rem, half;
        ex = int'(x[30:23]);
        ez = int'(z[30:23]);
        s  = x[31] ^ z[31];
        if ((ex == 255 && x[22:0] != 0) || (ez == 255 && z[22:0] != 0)) return 32'h7FC0_0000;
        if ((ex == 255 && ez == 0) || (ez == 255 && ex == 0)) return 32'h7FC0_0000;
        if (ex == 255 || ez == 255) return {s, 8'hFF, 23'd0};
        if (ex == 0 || ez == 0) return {s, 31'd0};
        p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, z[22:0]});
        e  = ex + ez - 127;
        sh = p[47] ? 24 : 23;
        if (p[47]) e++;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    // Cycle-level expectation: m_cnt counts cycles since acceptance, done at 27.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_y = 32'd0;
    logic [31:0] m_res = 32'd0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_y    <= 32'd0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_res  <= ref_mul(a, b);
            end
        end else if (m_cnt == 27) begin
            m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 26) m_y <= m_res;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, (m_busy && m_cnt == 27)});
            chk("y", y, m_y);
        end
    end

    task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] z,
                          input logic [31:0] exp);
        int got_k;
        got_k = 0;
        @(negedge clock);
        a = x; b = z; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            start = 1'b0;
            a = $urandom; b = $urandom;
            if (done) begin
                got_k = k;
                break;
            end
        end
        chk({nm, " latency"}, got_k, 27);
        chk(nm, y, exp);
    endtask

    task automatic ignore_test();
        int ndone, dk;
        ndone = 0; dk = 0;
        @(negedge clock);
        a = 32'h4000_0000; b = 32'h4040_0000; start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (done) begin
                ndone++;
                if (ndone == 1) dk = k;
            end
            start = (k == 5 || k == 27);
            if (start) begin
                a = 32'h4120_0000; b = 32'h4120_0000;
            end else begin
                a = $urandom; b = $urandom;
            end
        end
        start = 1'b0;
        chk("ignore latency", dk, 27);
        chk("ignore done count", ndone, 1);
        chk("ignore y", y, 32'h40C0_0000);
    endtask

    task automatic reset_test();
        int ndone, dk;
        ndone = 0; dk = 0;
        @(negedge clock);
        a = 32'h3FC0_0000; b = 32'h3FC0_0000; start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (done) begin
                ndone++;
                if (ndone == 1) dk = k;
            end
            if (k == 11) begin
                chk("abort y", y, 32'h0);
                chk("abort busy", {31'd0, busy}, 32'h0);
            end
            reset = (k == 10);
            start = (k == 10 || k == 12);
            if (k == 12) begin
                a = 32'h4000_0000; b = 32'h4040_0000;
            end else begin
                a = $urandom; b = $urandom;
            end
        end
        start = 1'b0;
        chk("restart latency", dk, 39);
        chk("restart done count", ndone, 1);
        chk("restart y", y, 32'h40C0_0000);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        chk("reset y", y, 32'h0);
        reset = 1'b0;
        run_op("2*3",        32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        run_op("1.5*1.5",    32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        run_op("-1*2",       32'hBF80_0000, 32'h4000_0000, 32'hC000_0000);
        run_op("sticky rnd", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        run_op("tie odd",    32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
        run_op("tie even",   32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004);
        run_op("overflow",   32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
        run_op("underflow",  32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
        run_op("inf*0",      32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        run_op("0*inf",      32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000);
        run_op("denorm",     32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
        run_op("nan",        32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
        run_op("inf*-2",     32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000);
        run_op("-0*3",       32'h8000_0000, 32'h4040_0000, 32'h8000_0000);
        ignore_test();
        reset_test();
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
